sevenseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. Holds a 16-bit value of four BCD/hex nibbles and sequences a single shared nibble-to-segment decoder across the four digits. It drives one anode at a time, inserts a blanking guard between digits to suppress ghosting, and applies optional leading-zero suppression. It sits between the value-producing logic and the board's display pins.

---
 rtl/sevenseg_pkg.sv | 30 +++
 rtl/hex_to_7seg.sv | 33 +++
 rtl/sevenseg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Active-low segment patterns {g,f,e,d,c,b,a} and scan state encoding.
package sevenseg_pkg;

    localparam int NDIG = 4;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low seven-segment decoder.
// Shared by all four digits through the scan controller's digit mux.
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex nibble
    always_comb begin
        seg = SEG_OFF;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit common-anode scan controller with blanking guard,
// frame-synchronous value commit and leading-zero suppression.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] d,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DIV_END   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);

    scan_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [19:0]   shadow, shadow_n;
    logic [19:0]   disp, disp_n;
    logic          pend, pend_n;
    logic          commit;
    logic [3:0]    nib;
    logic          lz_hit;
    logic          dp_bit;
    logic [6:0]    dec;
    logic [6:0]    seg_n;
    logic [3:0]    an_n;
    logic          dp_n;
    logic          fd_n;

    // Scan sequencing: BLANK guard then DRIVE for each digit in turn
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        if (state == BLANK) begin
            if (cnt == GUARD_END) begin
                state_n = DRIVE;
                cnt_n   = '0;
            end
        end else if (cnt == DIV_END) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
        end
    end

    assign commit = (state == DRIVE) && (idx == 2'd3) && (cnt == DIV_END);

    // Load capture and frame-boundary commit; a load on the commit
    // cycle bypasses the shadow so it is never lost or delayed
    always_comb begin
        shadow_n = shadow;
        pend_n   = pend;
        disp_n   = disp;
        if (load) begin
            shadow_n = {dp_in, d};
        end
        if (commit) begin
            pend_n = 1'b0;
            if (load) begin
                disp_n = {dp_in, d};
            end else if (pend) begin
                disp_n = shadow;
            end
        end else if (load) begin
            pend_n = 1'b1;
        end
    end

    // Select the nibble, dp bit and zero-run flag for the next digit
    always_comb begin
        nib    = disp_n[3:0];
        dp_bit = disp_n[16];
        lz_hit = 1'b0;
        unique case (idx_n)
            2'd0: begin
                nib    = disp_n[3:0];
                dp_bit = disp_n[16];
                lz_hit = 1'b0;
            end
            2'd1: begin
                nib    = disp_n[7:4];
                dp_bit = disp_n[17];
                lz_hit = (disp_n[15:4] == 12'h000);
            end
            2'd2: begin
                nib    = disp_n[11:8];
                dp_bit = disp_n[18];
                lz_hit = (disp_n[15:8] == 8'h00);
            end
            2'd3: begin
                nib    = disp_n[15:12];
                dp_bit = disp_n[19];
                lz_hit = (disp_n[15:12] == 4'h0);
            end
        endcase
    end

    hex_to_7seg u_dec (
        .nib (nib),
        .seg (dec)
    );

    // Next registered output values, aligned with the next state
    always_comb begin
        seg_n = SEG_OFF;
        an_n  = 4'hF;
        dp_n  = 1'b1;
        fd_n  = 1'b0;
        if (state_n == DRIVE) begin
            seg_n = (blank_lz && lz_hit) ? SEG_OFF : dec;
            an_n  = ~(4'b0001 << idx_n);
            dp_n  = ~dp_bit;
            fd_n  = (idx_n == 2'd3) && (cnt_n == DIV_END);
        end
    end

    // State, data and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= '0;
            disp       <= '0;
            pend       <= 1'b0;
            seg        <= SEG_OFF;
            an         <= 4'hF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shadow     <= shadow_n;
            disp       <= disp_n;
            pend       <= pend_n;
            seg        <= seg_n;
            an         <= an_n;
            dp         <= dp_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl with DIV=4, GUARD=1.
// Expected outputs come from a phase/frame model of the display.
module tb_sevenseg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int GUARD = 1;
    localparam int DPER  = DIV + GUARD;
    localparam int FPER  = 4 * DPER;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] d;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    int          k;
    logic [19:0] shown;
    logic [19:0] pval;
    bit          pvalid;
    bit          lz_prev;
    logic [6:0]  tbl [16];

    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;

    sevenseg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .d          (d),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic bit is_fd(int c);
        return ((c % FPER) / DPER == 3) && ((c % DPER) == DPER - 1);
    endfunction

    task automatic model_out();
        int ph;
        int dig;
        int w;
        logic [15:0] hi;
        ph = k % FPER;
        dig = ph / DPER;
        w = ph % DPER;
        e_fd = is_fd(k);
        if (w < GUARD) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            hi    = shown[15:0] >> (4 * dig);
            e_an  = ~(4'b0001 << dig);
            e_dp  = ~shown[16 + dig];
            if (lz_prev && dig != 0 && hi == 16'h0)
                e_seg = 7'h7F;
            else
                e_seg = tbl[hi[3:0]];
        end
    endtask

    task automatic tick(bit ld, logic [15:0] dv, logic [3:0] dpv, bit lz);
        load     = ld;
        d        = dv;
        dp_in    = dpv;
        blank_lz = lz;
        if (is_fd(k)) begin
            if (ld) shown = {dpv, dv};
            else if (pvalid) shown = pval;
            pvalid = 0;
        end else if (ld) begin
            pval   = {dpv, dv};
            pvalid = 1;
        end
        lz_prev = lz;
        @(posedge clk);
        #1;
        k++;
        load = 1'b0;
        model_out();
    endtask

    task automatic model_reset();
        k = 0;
        shown = '0;
        pvalid = 0;
        lz_prev = 0;
        blank_lz = 1'b0;
        model_out();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load = 1'b0;
        d = '0;
        dp_in = '0;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_init an=%h seg=%h dp=%b fd=%b want F/7f/1/0",
                     an, seg, dp, frame_done);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 7; i++) begin
            tick(i == 3, 16'h1234, 4'hF, 0);
            n_cmp++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_bad++;
                $display("FAIL pre_reset k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_async an=%h seg=%h dp=%b fd=%b want F/7f/1/0",
                     an, seg, dp, frame_done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_startup();
        int fds;
        fds = 0;
        for (int i = 0; i < 2 * FPER; i++) begin
            tick(0, 16'h0, 4'h0, 0);
            if (frame_done === 1'b1) fds++;
            n_cmp++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_bad++;
                $display("FAIL startup k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
        n_cmp++;
        if (fds != 2) begin
            n_bad++;
            $display("FAIL startup_fd_count got %0d want 2", fds);
        end
    endtask

    task automatic test_load_dp();
        for (int i = 0; i < 50; i++) begin
            tick(i == 6, 16'h1234, 4'b0100, 0);
            n_cmp++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_bad++;
                $display("FAIL load_dp k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
    endtask

    task automatic test_lz();
        for (int i = 0; i < 70; i++) begin
            tick(i == 2, 16'h0007, 4'h0, i < 50);
            n_cmp++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_bad++;
                $display("FAIL lz k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
    endtask

    task automatic test_midframe();
        bit done1;
        bit done2;
        int ph;
        done1 = 0;
        done2 = 0;
        for (int i = 0; i < 80; i++) begin
            ph = k % FPER;
            if (!done1 && ph / DPER == 1 && ph % DPER >= GUARD) begin
                tick(1, 16'h5678, 4'h0, 0);
                done1 = 1;
            end else if (done1 && !done2 && ph / DPER == 2 &&
                         ph % DPER >= GUARD) begin
                tick(1, 16'h9ABC, 4'h0, 0);
                done2 = 1;
            end else begin
                tick(0, 16'h0, 4'h0, 0);
            end
            n_cmp++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_bad++;
                $display("FAIL midframe k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
    endtask

    task automatic test_coincident();
        int guard_cnt;
        guard_cnt = 0;
        while (!is_fd(k) && guard_cnt < 2 * FPER) begin
            tick(0, 16'h0, 4'h0, 0);
            guard_cnt++;
        end
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL coinc_fd got %b want 1 (waited %0d)",
                     frame_done, guard_cnt);
        end
        tick(1, 16'hFFFF, 4'h0, 0);
        for (int i = 0; i < 2 * FPER; i++) begin
            n_cmp++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_bad++;
                $display("FAIL coinc k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
            tick(0, 16'h0, 4'h0, 0);
        end
    endtask

    task automatic test_random();
        bit lz;
        lz = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) lz = ~lz;
            tick($urandom_range(5) == 0,
                 16'($urandom_range(3) == 0 ? $urandom_range(255) : $urandom),
                 4'($urandom), lz);
            n_cmp++;
            if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
                n_bad++;
                $display("FAIL random k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
            end
        end
    endtask

    initial begin
        tbl[0]  = 7'h40; tbl[1]  = 7'h79; tbl[2]  = 7'h24; tbl[3]  = 7'h30;
        tbl[4]  = 7'h19; tbl[5]  = 7'h12; tbl[6]  = 7'h02; tbl[7]  = 7'h78;
        tbl[8]  = 7'h00; tbl[9]  = 7'h10; tbl[10] = 7'h08; tbl[11] = 7'h03;
        tbl[12] = 7'h46; tbl[13] = 7'h21; tbl[14] = 7'h06; tbl[15] = 7'h0E;
        test_reset();
        test_startup();
        test_load_dp();
        test_lz();
        test_midframe();
        test_coincident();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
